// File: rtl/aibcr3_buffxn_pkg.sv
// Shared definitions for the AIB IO buffer control slice: channel FSM encoding,
// step-counter sizing and the one-LSB step-toward helper.
package aibcr3_buffxn_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_RAMP   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_RAMPDN = 2'd3
    } ch_state_e;

    localparam int CODE_MAXW = 16;

    function automatic int cnt_width(input int ramp_cyc);
        return ($clog2(ramp_cyc) < 1) ? 1 : $clog2(ramp_cyc);
    endfunction

    // Move one LSB toward goal, saturating at goal.
    function automatic logic [CODE_MAXW-1:0] step_toward(input logic [CODE_MAXW-1:0] cur,
                                                          input logic [CODE_MAXW-1:0] goal);
        if (cur < goal)
            return cur + CODE_MAXW'(1);
        else if (cur > goal)
            return cur - CODE_MAXW'(1);
        else
            return cur;
    endfunction

endpackage

// File: rtl/aibcr3_buffxn_chctl.sv
// One IO-buffer channel: enable/drive-strength ramp FSM, launch-data gating and
// weak-pull registers. All outputs are registered from the next state.
module aibcr3_buffxn_chctl
    import aibcr3_buffxn_pkg::*;
#(
    parameter int DRVW     = 2,
    parameter int RAMP_CYC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            padrst_n,
    input  logic            txen,
    input  logic [DRVW-1:0] pdrv,
    input  logic [DRVW-1:0] ndrv,
    input  logic            dat0,
    input  logic            dat1,
    input  logic            lpbk_en,
    input  logic            lpbk_dat,
    input  logic            testmode_en,
    input  logic            test_weakpu,
    input  logic            test_weakpd,
    output logic            tx_en,
    output logic [DRVW-1:0] pcode,
    output logic [DRVW-1:0] ncode,
    output logic            tx_dat0,
    output logic            tx_dat1,
    output logic            pullupenb,
    output logic            pulldownen,
    output logic            ready
);

    localparam int CW = cnt_width(RAMP_CYC);

    ch_state_e       st, st_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [DRVW-1:0] p_nxt, n_nxt, p_up, n_up, p_dn, n_dn;
    logic            stp, tgt_match;

    always_comb begin
        stp       = (cnt == CW'(RAMP_CYC - 1));
        cnt_inc   = stp ? '0 : cnt + 1'b1;
        p_up      = DRVW'(step_toward(CODE_MAXW'(pcode), CODE_MAXW'(pdrv)));
        n_up      = DRVW'(step_toward(CODE_MAXW'(ncode), CODE_MAXW'(ndrv)));
        p_dn      = DRVW'(step_toward(CODE_MAXW'(pcode), '0));
        n_dn      = DRVW'(step_toward(CODE_MAXW'(ncode), '0));
        tgt_match = (pcode == pdrv) && (ncode == ndrv);
        st_nxt    = st;
        cnt_nxt   = cnt;
        p_nxt     = pcode;
        n_nxt     = ncode;
        if (!padrst_n) begin
            st_nxt  = ST_OFF;
            cnt_nxt = '0;
            p_nxt   = '0;
            n_nxt   = '0;
        end else begin
            case (st)
                ST_OFF: begin
                    if (txen) begin
                        st_nxt  = ST_RAMP;
                        cnt_nxt = '0;
                    end
                end
                ST_RAMP: begin
                    cnt_nxt = cnt_inc;
                    if (stp) begin
                        p_nxt = p_up;
                        n_nxt = n_up;
                    end
                    if (!txen) begin
                        st_nxt  = ST_RAMPDN;
                        cnt_nxt = '0;
                    end else if (stp && p_up == pdrv && n_up == ndrv) begin
                        st_nxt = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // ready still high means this is the first mismatch cycle: restart the step timer
                    if (tgt_match || ready) begin
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (stp) begin
                            p_nxt = p_up;
                            n_nxt = n_up;
                        end
                    end
                    if (!txen) begin
                        st_nxt  = ST_RAMPDN;
                        cnt_nxt = '0;
                    end
                end
                default: begin
                    cnt_nxt = cnt_inc;
                    if (stp) begin
                        p_nxt = p_dn;
                        n_nxt = n_dn;
                    end
                    if (txen) begin
                        st_nxt  = ST_RAMP;
                        cnt_nxt = '0;
                    end else if (stp && p_dn == '0 && n_dn == '0) begin
                        st_nxt = ST_OFF;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_OFF;
            cnt        <= '0;
            pcode      <= '0;
            ncode      <= '0;
            tx_en      <= 1'b0;
            tx_dat0    <= 1'b0;
            tx_dat1    <= 1'b0;
            ready      <= 1'b0;
            pulldownen <= 1'b1;
            pullupenb  <= 1'b1;
        end else begin
            st         <= st_nxt;
            cnt        <= cnt_nxt;
            pcode      <= p_nxt;
            ncode      <= n_nxt;
            tx_en      <= (st_nxt != ST_OFF);
            ready      <= (st_nxt == ST_ACTIVE) && (p_nxt == pdrv) && (n_nxt == ndrv);
            tx_dat0    <= (st_nxt == ST_ACTIVE) && (lpbk_en ? lpbk_dat : dat0);
            tx_dat1    <= (st_nxt == ST_ACTIVE) && (lpbk_en ? lpbk_dat : dat1);
            pulldownen <= testmode_en ? test_weakpd : (st_nxt == ST_OFF);
            pullupenb  <= testmode_en ? ~(test_weakpu & ~test_weakpd) : 1'b1;
        end
    end

endmodule

// File: rtl/aibcr3_buffxn_ctrl.sv
// N-channel AIB IO buffer control: fans shared controls out to per-channel
// controllers and synchronises asynchronous pad receive data.
module aibcr3_buffxn_ctrl
    import aibcr3_buffxn_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DRVW     = 2,
    parameter int RAMP_CYC = 4
) (
    input  logic                ilaunch_clk,
    input  logic                irstb,
    input  logic                ipadrstb,
    input  logic [NCH-1:0]      itxen,
    input  logic [DRVW-1:0]     ipdrv,
    input  logic [DRVW-1:0]     indrv,
    input  logic [NCH-1:0]      idat0,
    input  logic [NCH-1:0]      idat1,
    input  logic                ilpbk_en,
    input  logic [NCH-1:0]      ilpbk_dat,
    input  logic                testmode_en,
    input  logic                test_weakpu,
    input  logic                test_weakpd,
    input  logic [NCH-1:0]      rx_idat,
    output logic [NCH-1:0]      itx_en_buf,
    output logic [NCH*DRVW-1:0] ipdrv_buf,
    output logic [NCH*DRVW-1:0] indrv_buf,
    output logic [NCH-1:0]      tx_dat0,
    output logic [NCH-1:0]      tx_dat1,
    output logic [NCH-1:0]      weak_pullupenb,
    output logic [NCH-1:0]      weak_pulldownen,
    output logic [NCH-1:0]      ready,
    output logic [NCH-1:0]      odat_async
);

    logic [1:0][NCH-1:0] rx_pipe;

    always_ff @(posedge ilaunch_clk or negedge irstb) begin
        if (!irstb)
            rx_pipe <= '0;
        else
            rx_pipe <= {rx_pipe[0], rx_idat};
    end

    assign odat_async = rx_pipe[1];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        aibcr3_buffxn_chctl #(
            .DRVW     (DRVW),
            .RAMP_CYC (RAMP_CYC)
        ) u_ch (
            .clk         (ilaunch_clk),
            .rst_n       (irstb),
            .padrst_n    (ipadrstb),
            .txen        (itxen[k]),
            .pdrv        (ipdrv),
            .ndrv        (indrv),
            .dat0        (idat0[k]),
            .dat1        (idat1[k]),
            .lpbk_en     (ilpbk_en),
            .lpbk_dat    (ilpbk_dat[k]),
            .testmode_en (testmode_en),
            .test_weakpu (test_weakpu),
            .test_weakpd (test_weakpd),
            .tx_en       (itx_en_buf[k]),
            .pcode       (ipdrv_buf[k*DRVW +: DRVW]),
            .ncode       (indrv_buf[k*DRVW +: DRVW]),
            .tx_dat0     (tx_dat0[k]),
            .tx_dat1     (tx_dat1[k]),
            .pullupenb   (weak_pullupenb[k]),
            .pulldownen  (weak_pulldownen[k]),
            .ready       (ready[k])
        );
    end

endmodule

// File: doc/aibcr3_buffxn_ctrl.md
# aibcr3_buffxn_ctrl

Parametrised N-channel digital control block for the AIB IO buffer. It sits between the adapter-side controls and the per-pad analog cells. Per channel, it sequences transmitter enable and drive strength through a stepped ramp that limits simultaneous-switching current, and gates and registers DDR launch data. It also owns the weak pull-up/pull-down controls and synchronises the asynchronous receive data, which the single-channel buffer does not do.

## Interface
- NCH, 4: channel count (≥1)
- DRVW, 2: drive-code width; maximum code 2^DRVW−1
- RAMP_CYC, 4: clock cycles per drive-code step (≥1)

- ilaunch_clk  in  1  sole clock; all state on rising edge
- irstb  in  1  reset; asynchronous, active-low
- ipadrstb  in  1  pad reset, active-low, sampled synchronously; forces all channels to OFF
- itxen  in  NCH  per-channel transmit request
- ipdrv  in  DRVW  target pull-up drive code, shared by all channels
- indrv  in  DRVW  target pull-down drive code, shared by all channels
- idat0, idat1  in  NCH each  rising/falling launch data
- ilpbk_en  in  1  loopback: TX data source becomes ilpbk_dat
- ilpbk_dat  in  NCH  loopback data, used for both phases
- testmode_en, test_weakpu, test_weakpd  in  1 each  weak-pull test overrides
- rx_idat  in  NCH  asynchronous pad receive data
- itx_en_buf  out  NCH  analog TX enable
- ipdrv_buf, indrv_buf  out  NCH*DRVW each  applied drive codes; channel k occupies bits [k*DRVW +: DRVW]
- tx_dat0, tx_dat1  out  NCH each  registered launch data
- weak_pullupenb  out  NCH  weak pull-up enable, active-low
- weak_pulldownen  out  NCH  weak pull-down enable
- ready  out  NCH  channel ACTIVE and codes equal target
- odat_async  out  NCH  rx_idat after a 2-flop synchroniser

## Operation
- Each channel has a 4-state FSM: OFF, RAMP, ACTIVE, RAMPDN.
- OFF → RAMP: itxen=1 and ipadrstb=1. itx_en_buf rises on the same edge, and the step counter clears.
- Step engine:
  - The counter counts 0..RAMP_CYC−1. Its wrap edge is a "step edge".
  - On each step edge, each code moves by ±1 toward its goal and saturates at the goal.
  - Pull-up and pull-down codes step independently.
  - In RAMP and ACTIVE the goal is ipdrv/indrv. In RAMPDN the goal is 0.
- RAMP → ACTIVE: on the step edge at which both next codes equal target. With target 0, this is the first step edge.
- RAMP or ACTIVE → RAMPDN: when itxen=0. The counter clears.
- RAMPDN → OFF: on the step edge at which both next codes equal 0. itx_en_buf falls on that edge.
- RAMPDN → RAMP: when itxen=1. Codes are kept and the counter clears.
- Target change in ACTIVE:
  - State stays ACTIVE; ready drops the cycle after the mismatch is seen.
  - The counter clears on the first mismatch cycle, then stepping continues.
  - ready returns on the edge where the codes match.
- ipadrstb=0 in any state: next edge → OFF, codes 0, itx_en_buf 0. This overrides itxen.
- TX data:
  - In ACTIVE: tx_dat0←(ilpbk_en ? ilpbk_dat : idat0) and tx_dat1←(ilpbk_en ? ilpbk_dat : idat1).
  - In every other state, both are 0.
- Weak pulls (registered, evaluated from next state):
  - testmode_en=1, all states: pulldownen=test_weakpd; pullupenb=~(test_weakpu & ~test_weakpd). Pull-down wins if both are requested.
  - testmode_en=0, OFF: pulldownen=1, pullupenb=1.
  - testmode_en=0, other states: pulldownen=0, pullupenb=1.
- RX path: odat_async is rx_idat through 2 flops and is independent of FSM state.

## Timing
- Reset values:
  - State OFF; codes 0; counter 0.
  - itx_en_buf, tx_dat0/1, ready, odat_async all 0.
  - weak_pulldownen all 1; weak_pullupenb all 1.
- All outputs are registered.
- itxen → itx_en_buf: 1 cycle.
- Data: idat → tx_dat is 1 cycle in ACTIVE.
- ramp-up duration = RAMP_CYC·max(ipdrv, indrv, 1) cycles after RAMP entry.
- rx_idat → odat_async: 2–3 cycles.
- Simultaneous events:
  - ipadrstb=0 beats everything.
  - itxen toggling on a step edge: the transition is taken and the step is applied on that same edge.

## Structure
- Package aibcr3_buffxn_pkg holds:
  - the state encoding (OFF=2'd0, RAMP=2'd1, ACTIVE=2'd2, RAMPDN=2'd3);
  - the counter width clog2(RAMP_CYC) (minimum 1);
  - the step-toward function.
- Sub-module aibcr3_buffxn_chctl holds one channel (FSM, step engine, data, pull registers). It is instantiated NCH times through generate.
- The top level adds the shared-input fan-out and the RX synchronisers.

## Test plan
- Defaults (NCH=4, DRVW=2, RAMP_CYC=4), ipdrv=3, indrv=2, itxen[0] 0→1: itx_en_buf[0] at +1 cycle, then:
  - ipdrv_buf[1:0]=1, 2, 3 at +5, +9, +13;
  - indrv_buf[1:0]=1, 2 at +5, +9, holding 2 thereafter;
  - ready[0] at +13. Channels 1–3 stay OFF.
- In ACTIVE, idat0=1, idat1=0, then ilpbk_en=1 with ilpbk_dat[0]=1: tx_dat0/1 = 1/0 after one cycle, then 1/1.
- itxen[0] dropped at code 2 mid-RAMP: codes reach 1 after 4 cycles and 0 after 8 cycles; itx_en_buf[0]=0 on the same edge as code 0; weak_pulldownen[0]=1 on that edge.
- ipadrstb=0 while ACTIVE on all channels: next edge all codes 0, itx_en_buf=0, ready=0, tx_dat=0.
- testmode_en=1 with test_weakpu=test_weakpd=1, then test_weakpd=0: pulldownen=1/pullupenb=1, then pulldownen=0/pullupenb=0.
- Reset asserted mid-ramp and rx_idat pulse check: all outputs return to reset values asynchronously. A rx_idat step appears on odat_async within 3 cycles.
